// File: rtl/step_rate_scheduler.sv
// Step-rate scheduler: feeds one axis divider a linear accel/cruise/decel divisor profile (ramp built only with STEP_RAMP_EN).
// Latency: accept -> div_en next cycle; each tick -> div_out/steps_left next cycle; last tick -> done next cycle.
// Backpressure: cmd_ready only in IDLE; a command held valid across DONE is taken on the first IDLE cycle.
module step_rate_scheduler #(
    parameter int DIV_BITS  = 8,
    parameter int STEP_BITS = 16,
    parameter int START_DIV = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [STEP_BITS-1:0] cmd_steps,
    input  logic [DIV_BITS-1:0]  cmd_div,
    input  logic                 cmd_dir,
    input  logic                 abort,
    input  logic                 tick,
    output logic [DIV_BITS-1:0]  div_out,
    output logic                 div_en,
    output logic                 step_dir,
    output logic                 busy,
    output logic [STEP_BITS-1:0] steps_left,
    output logic                 done,
    output logic                 aborted
);

    typedef enum logic [2:0] {IDLE, ACCEL, CRUISE, DECEL, DONE} state_t;

    localparam logic [DIV_BITS-1:0]  START_D = DIV_BITS'(START_DIV);
    localparam logic [DIV_BITS-1:0]  ONE_D   = DIV_BITS'(1);
    localparam logic [STEP_BITS-1:0] ONE_S   = STEP_BITS'(1);

    state_t                state, state_nxt;
    logic [DIV_BITS-1:0]   cur_div, cur_div_nxt;
    logic [STEP_BITS-1:0]  steps_nxt, r;
    logic                  dir_nxt, aborted_nxt, active_nxt;
    logic [DIV_BITS-1:0]   cmd_tgt;
`ifdef STEP_RAMP_EN
    logic [DIV_BITS-1:0]   tgt_div, tgt_nxt, acc_cnt, acc_nxt;
    logic [STEP_BITS-1:0]  acc_ext;

    assign acc_ext = STEP_BITS'(acc_cnt);
`endif

    assign cmd_ready = (state == IDLE) & ~reset;
    assign cmd_tgt   = (cmd_div == '0) ? ONE_D : cmd_div;
    assign r         = steps_left - ONE_S;
    assign div_out   = cur_div;
    assign active_nxt = (state_nxt == ACCEL) || (state_nxt == CRUISE) || (state_nxt == DECEL);

    always_comb begin
        state_nxt   = state;
        cur_div_nxt = cur_div;
        steps_nxt   = steps_left;
        dir_nxt     = step_dir;
        aborted_nxt = 1'b0;
`ifdef STEP_RAMP_EN
        tgt_nxt     = tgt_div;
        acc_nxt     = acc_cnt;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    steps_nxt = cmd_steps;
                    dir_nxt   = cmd_dir;
`ifdef STEP_RAMP_EN
                    tgt_nxt   = cmd_tgt;
                    acc_nxt   = '0;
                    if (cmd_steps == '0) begin
                        state_nxt = DONE;
                    end else if (cmd_tgt >= START_D) begin
                        cur_div_nxt = cmd_tgt;
                        state_nxt   = CRUISE;
                    end else begin
                        cur_div_nxt = START_D;
                        state_nxt   = ACCEL;
                    end
`else
                    if (cmd_steps == '0) begin
                        state_nxt = DONE;
                    end else begin
                        cur_div_nxt = cmd_tgt;
                        state_nxt   = CRUISE;
                    end
`endif
                end
            end
            ACCEL, CRUISE, DECEL: begin
                // abort wins over a coincident tick and leaves the step count untouched
                if (abort) begin
                    state_nxt   = DONE;
                    aborted_nxt = 1'b1;
                end else if (tick) begin
                    steps_nxt = r;
                    if (r == '0) begin
                        state_nxt = DONE;
                    end else begin
`ifdef STEP_RAMP_EN
                        case (state)
                            ACCEL: begin
                                if (r <= acc_ext) begin
                                    state_nxt   = DECEL;
                                    cur_div_nxt = cur_div + ONE_D;
                                    acc_nxt     = acc_cnt - ONE_D;
                                end else begin
                                    cur_div_nxt = cur_div - ONE_D;
                                    acc_nxt     = acc_cnt + ONE_D;
                                    if ((cur_div - ONE_D) == tgt_div) state_nxt = CRUISE;
                                end
                            end
                            CRUISE: begin
                                // start braking once the remaining steps match the steps spent speeding up
                                if (r <= acc_ext) begin
                                    state_nxt   = DECEL;
                                    cur_div_nxt = cur_div + ONE_D;
                                    acc_nxt     = acc_cnt - ONE_D;
                                end
                            end
                            DECEL: begin
                                if (cur_div < START_D) cur_div_nxt = cur_div + ONE_D;
                                if (acc_cnt != '0)     acc_nxt     = acc_cnt - ONE_D;
                            end
                            default: ;
                        endcase
`endif
                    end
                end
            end
            DONE: begin
                state_nxt   = IDLE;
                cur_div_nxt = START_D;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_div    <= START_D;
            steps_left <= '0;
            step_dir   <= 1'b0;
            div_en     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
`ifdef STEP_RAMP_EN
            tgt_div    <= START_D;
            acc_cnt    <= '0;
`endif
        end else begin
            state      <= state_nxt;
            cur_div    <= cur_div_nxt;
            steps_left <= steps_nxt;
            step_dir   <= dir_nxt;
            div_en     <= active_nxt;
            busy       <= active_nxt;
            done       <= (state_nxt == DONE);
            aborted    <= aborted_nxt;
`ifdef STEP_RAMP_EN
            tgt_div    <= tgt_nxt;
            acc_cnt    <= acc_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_step_rate_scheduler.sv
// Directed bench for step_rate_scheduler (START_DIV=10); ramp expectations apply when STEP_RAMP_EN is defined.
module tb_step_rate_scheduler;

    localparam int DB = 8;
    localparam int SB = 16;
    localparam int SD = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [SB-1:0] cmd_steps = '0;
    logic [DB-1:0] cmd_div = '0;
    logic          cmd_dir = 1'b0;
    logic          abort = 1'b0;
    logic          tick = 1'b0;
    logic [DB-1:0] div_out;
    logic          div_en;
    logic          step_dir;
    logic          busy;
    logic [SB-1:0] steps_left;
    logic          done;
    logic          aborted;

    int n_total = 0;
    int n_pass  = 0;

    step_rate_scheduler #(.DIV_BITS(DB), .STEP_BITS(SB), .START_DIV(SD)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_steps  (cmd_steps),
        .cmd_div    (cmd_div),
        .cmd_dir    (cmd_dir),
        .abort      (abort),
        .tick       (tick),
        .div_out    (div_out),
        .div_en     (div_en),
        .step_dir   (step_dir),
        .busy       (busy),
        .steps_left (steps_left),
        .done       (done),
        .aborted    (aborted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic send(input int steps, input int dv, input logic dir);
        int waited;
        waited = 0;
        while (!cmd_ready && waited < 20) begin
            step();
            waited++;
        end
        check("send_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_steps = SB'(steps);
        cmd_div   = DB'(dv);
        cmd_dir   = dir;
        step();
        cmd_valid = 1'b0;
    endtask

`ifdef STEP_RAMP_EN
    int ramp_exp[19] = '{9, 8, 7, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 6, 7, 8, 9, 10};
    int short_exp[3] = '{9, 8, 9};
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        step();
        step();
        check("rst_cmd_ready",  32'(cmd_ready),  32'd0);
        check("rst_div_out",    32'(div_out),    32'd10);
        check("rst_div_en",     32'(div_en),     32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done",       32'(done),       32'd0);
        check("rst_aborted",    32'(aborted),    32'd0);
        check("rst_step_dir",   32'(step_dir),   32'd0);
        check("rst_steps_left", 32'(steps_left), 32'd0);
        reset = 1'b0;
        #1;
        check("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_aborted", 32'(aborted), 32'd0);
        check("idle_abort_done",    32'(done),    32'd0);

`ifdef STEP_RAMP_EN
        send(20, 6, 1'b1);
        check("ramp_div_en",  32'(div_en),     32'd1);
        check("ramp_busy",    32'(busy),       32'd1);
        check("ramp_dir",     32'(step_dir),   32'd1);
        check("ramp_steps",   32'(steps_left), 32'd20);
        check("ramp_div0",    32'(div_out),    32'd10);
        for (int i = 0; i < 19; i++) begin
            do_tick();
            check($sformatf("ramp_div_t%0d", i + 1), 32'(div_out), 32'(ramp_exp[i]));
            check($sformatf("ramp_left_t%0d", i + 1), 32'(steps_left), 32'(19 - i));
            step();
        end
        do_tick();
        check("ramp_done",     32'(done),       32'd1);
        check("ramp_end_en",   32'(div_en),     32'd0);
        check("ramp_end_left", 32'(steps_left), 32'd0);
        check("ramp_aborted",  32'(aborted),    32'd0);
        step();
        check("ramp_done_pulse", 32'(done),      32'd0);
        check("ramp_ready_back", 32'(cmd_ready), 32'd1);

        send(4, 2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            check($sformatf("short_div_t%0d", i + 1), 32'(div_out), 32'(short_exp[i]));
            check($sformatf("short_done_t%0d", i + 1), 32'(done), 32'd0);
            step();
        end
        do_tick();
        check("short_done", 32'(done), 32'd1);
        step();
`else
        send(5, 3, 1'b0);
        check("flat_div0",   32'(div_out), 32'd3);
        check("flat_div_en", 32'(div_en),  32'd1);
        for (int i = 0; i < 4; i++) begin
            do_tick();
            check($sformatf("flat_div_t%0d", i + 1), 32'(div_out), 32'd3);
            check($sformatf("flat_left_t%0d", i + 1), 32'(steps_left), 32'(4 - i));
            check($sformatf("flat_done_t%0d", i + 1), 32'(done), 32'd0);
            step();
        end
        do_tick();
        check("flat_done",   32'(done),   32'd1);
        check("flat_end_en", 32'(div_en), 32'd0);
        step();
        check("flat_done_pulse", 32'(done),    32'd0);
        check("flat_div_restore", 32'(div_out), 32'd10);
`endif

        send(0, 5, 1'b0);
        check("zero_done",   32'(done),      32'd1);
        check("zero_div_en", 32'(div_en),    32'd0);
        check("zero_busy",   32'(busy),      32'd0);
        check("zero_ready",  32'(cmd_ready), 32'd0);
        step();
        check("zero_done_pulse", 32'(done),      32'd0);
        check("zero_ready_back", 32'(cmd_ready), 32'd1);
        check("zero_div_en2",    32'(div_en),    32'd0);

        send(10, 12, 1'b0);
        check("abt_div", 32'(div_out), 32'd12);
        for (int i = 0; i < 3; i++) begin
            do_tick();
            step();
        end
        check("abt_left_pre", 32'(steps_left), 32'd7);
        tick  = 1'b1;
        abort = 1'b1;
        step();
        tick  = 1'b0;
        abort = 1'b0;
        check("abt_div_en",  32'(div_en),     32'd0);
        check("abt_done",    32'(done),       32'd1);
        check("abt_aborted", 32'(aborted),    32'd1);
        check("abt_left",    32'(steps_left), 32'd7);
        step();
        check("abt_aborted_pulse", 32'(aborted),   32'd0);
        check("abt_done_pulse",    32'(done),      32'd0);
        check("abt_ready_back",    32'(cmd_ready), 32'd1);

        send(10, 5, 1'b1);
        do_tick();
        step();
        do_tick();
`ifdef STEP_RAMP_EN
        check("rstmv_div_pre", 32'(div_out), 32'd8);
`else
        check("rstmv_div_pre", 32'(div_out), 32'd5);
`endif
        reset = 1'b1;
        step();
        check("rstmv_div_out", 32'(div_out),    32'd10);
        check("rstmv_div_en",  32'(div_en),     32'd0);
        check("rstmv_busy",    32'(busy),       32'd0);
        check("rstmv_done",    32'(done),       32'd0);
        check("rstmv_dir",     32'(step_dir),   32'd0);
        check("rstmv_left",    32'(steps_left), 32'd0);
        check("rstmv_ready",   32'(cmd_ready),  32'd0);
        reset = 1'b0;
        step();
        check("rstmv_no_done", 32'(done),      32'd0);
        check("rstmv_ready2",  32'(cmd_ready), 32'd1);

        send(3, 0, 1'b0);
`ifdef STEP_RAMP_EN
        check("clamp_div0", 32'(div_out), 32'd10);
        do_tick();
        check("clamp_div1", 32'(div_out), 32'd9);
        step();
        do_tick();
        check("clamp_div2", 32'(div_out), 32'd10);
        step();
`else
        check("clamp_div0", 32'(div_out), 32'd1);
        do_tick();
        check("clamp_div1", 32'(div_out), 32'd1);
        step();
        do_tick();
        check("clamp_div2", 32'(div_out), 32'd1);
        step();
`endif
        cmd_valid = 1'b1;
        cmd_steps = SB'(2);
        cmd_div   = DB'(20);
        cmd_dir   = 1'b1;
        do_tick();
        check("b2b_done",      32'(done),      32'd1);
        check("b2b_ready_off", 32'(cmd_ready), 32'd0);
        step();
        check("b2b_ready_on",  32'(cmd_ready), 32'd1);
        check("b2b_done_off",  32'(done),      32'd0);
        step();
        cmd_valid = 1'b0;
        check("b2b_busy",  32'(busy),       32'd1);
        check("b2b_div",   32'(div_out),    32'd20);
        check("b2b_left",  32'(steps_left), 32'd2);
        check("b2b_dir",   32'(step_dir),   32'd1);
        do_tick();
        step();
        do_tick();
        check("b2b_end_done", 32'(done), 32'd1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
